// File: rtl/vga_pattern_gen_pkg.sv
// Shared mode encoding and colour-bar lookup for the VGA test-pattern generator.
package vga_pattern_pkg;

    typedef enum logic [3:0] {
        MODE_RED    = 4'd0,
        MODE_GREEN  = 4'd1,
        MODE_BLUE   = 4'd2,
        MODE_CUST   = 4'd3,
        MODE_BARS   = 4'd4,
        MODE_CHECK  = 4'd5,
        MODE_RAMP   = 4'd6,
        MODE_SCROLL = 4'd7,
        MODE_BLINK  = 4'd8,
        MODE_DFLT   = 4'd9
    } mode_e;

    // Channel enables {r,g,b}; the caller widens each bit to a full COLOR_W channel.
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] on;
        case (idx)
            3'd0:    on = 3'b111;
            3'd1:    on = 3'b110;
            3'd2:    on = 3'b011;
            3'd3:    on = 3'b010;
            3'd4:    on = 3'b101;
            3'd5:    on = 3'b100;
            3'd6:    on = 3'b001;
            default: on = 3'b000;
        endcase
        return on;
    endfunction

endpackage

// File: rtl/vga_pattern_gen_frame_ctrl.sv
// Frame-synchronous state: latched mode/colour, scroll offset and blink phase.
module vga_frame_ctrl
    import vga_pattern_pkg::*;
#(
    parameter int COLOR_W      = 8,
    parameter int CNT_W        = 10,
    parameter int H_ACTIVE     = 640,
    parameter int SCROLL_STEP  = 2,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic [3:0]           sw,
    input  logic [3*COLOR_W-1:0] cust_rgb,
    output logic [3:0]           mode_q,
    output logic [3*COLOR_W-1:0] cust_q,
    output logic [CNT_W-1:0]     offset,
    output logic                 blink_ph
);

    localparam int               FRM_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [CNT_W:0]   STEP     = (CNT_W+1)'(SCROLL_STEP);
    localparam logic [CNT_W:0]   HA       = (CNT_W+1)'(H_ACTIVE);

    logic [3:0]           r_mode_q;
    logic [3*COLOR_W-1:0] r_cust_q;
    logic [CNT_W-1:0]     r_offset;
    logic [FRM_W-1:0]     r_frm_cnt;
    logic                 r_blink_ph;

    logic [CNT_W:0] w_sum;
    logic           w_keep_scroll;

    assign w_sum         = {1'b0, r_offset} + STEP;
    // Scrolling only continues when the mode stays at scroll across the boundary.
    assign w_keep_scroll = (sw == MODE_SCROLL) && (r_mode_q == MODE_SCROLL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode_q   <= '0;
            r_cust_q   <= '0;
            r_offset   <= '0;
            r_frm_cnt  <= '0;
            r_blink_ph <= 1'b0;
        end else if (frame_start) begin
            r_mode_q <= sw;
            r_cust_q <= cust_rgb;
            if (r_frm_cnt == FRM_LAST) begin
                r_frm_cnt  <= '0;
                r_blink_ph <= ~r_blink_ph;
            end else begin
                r_frm_cnt <= r_frm_cnt + FRM_W'(1);
            end
            if (w_keep_scroll) begin
                r_offset <= (w_sum >= HA) ? CNT_W'(w_sum - HA) : CNT_W'(w_sum);
            end else begin
                r_offset <= '0;
            end
        end
    end

    assign mode_q   = r_mode_q;
    assign cust_q   = r_cust_q;
    assign offset   = r_offset;
    assign blink_ph = r_blink_ph;

endmodule

// File: rtl/vga_pattern_gen.sv
// Per-pixel test-pattern mux with one registered output stage between the
// timing generator and the video encoder.
module vga_pattern_gen
    import vga_pattern_pkg::*;
#(
    parameter int COLOR_W      = 8,
    parameter int CNT_W        = 10,
    parameter int H_ACTIVE     = 640,
    parameter int BAR_SHIFT    = 6,
    parameter int CHECK_SHIFT  = 5,
    parameter int SCROLL_STEP  = 2,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 active,
    input  logic                 frame_start,
    input  logic [CNT_W-1:0]     hcount,
    input  logic [CNT_W-1:0]     vcount,
    input  logic [3:0]           sw,
    input  logic [3*COLOR_W-1:0] cust_rgb,
    output logic [COLOR_W-1:0]   r,
    output logic [COLOR_W-1:0]   g,
    output logic [COLOR_W-1:0]   b,
    output logic                 active_o
);

    localparam logic [COLOR_W-1:0]   M        = '1;
    localparam logic [2*COLOR_W-1:0] ALT      = {COLOR_W{2'b10}};
    localparam logic [COLOR_W-1:0]   ORANGE_G = ALT[2*COLOR_W-1 -: COLOR_W];
    localparam logic [CNT_W:0]       HA       = (CNT_W+1)'(H_ACTIVE);

    logic [3:0]           w_mode_q;
    logic [3*COLOR_W-1:0] w_cust_q;
    logic [CNT_W-1:0]     w_offset;
    logic                 w_blink_ph;

    vga_frame_ctrl #(
        .COLOR_W      (COLOR_W),
        .CNT_W        (CNT_W),
        .H_ACTIVE     (H_ACTIVE),
        .SCROLL_STEP  (SCROLL_STEP),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_frame_ctrl (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .sw          (sw),
        .cust_rgb    (cust_rgb),
        .mode_q      (w_mode_q),
        .cust_q      (w_cust_q),
        .offset      (w_offset),
        .blink_ph    (w_blink_ph)
    );

    logic [CNT_W:0]     w_x_sum;
    logic [CNT_W:0]     w_x;
    logic [2:0]         w_bar_on;
    logic [2:0]         w_scr_on;
    logic               w_chk;
    logic [COLOR_W-1:0] w_r;
    logic [COLOR_W-1:0] w_g;
    logic [COLOR_W-1:0] w_b;
    logic               w_unused_ok;

    // One extra bit keeps hcount+offset from overflowing before the wrap.
    assign w_x_sum     = {1'b0, hcount} + {1'b0, w_offset};
    assign w_x         = (w_x_sum >= HA) ? (w_x_sum - HA) : w_x_sum;
    assign w_bar_on    = bar_rgb(hcount[BAR_SHIFT +: 3]);
    assign w_scr_on    = bar_rgb(w_x[BAR_SHIFT +: 3]);
    assign w_chk       = hcount[CHECK_SHIFT] ^ vcount[CHECK_SHIFT];
    assign w_unused_ok = ^{vcount, w_x};

    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        case (w_mode_q)
            MODE_RED:   w_r = M;
            MODE_GREEN: w_g = M;
            MODE_BLUE:  w_b = M;
            MODE_CUST: begin
                w_r = w_cust_q[3*COLOR_W-1 -: COLOR_W];
                w_g = w_cust_q[2*COLOR_W-1 -: COLOR_W];
                w_b = w_cust_q[COLOR_W-1:0];
            end
            MODE_BARS: begin
                w_r = {COLOR_W{w_bar_on[2]}};
                w_g = {COLOR_W{w_bar_on[1]}};
                w_b = {COLOR_W{w_bar_on[0]}};
            end
            MODE_CHECK: begin
                w_r = {COLOR_W{w_chk}};
                w_g = {COLOR_W{w_chk}};
                w_b = {COLOR_W{w_chk}};
            end
            MODE_RAMP: begin
                w_r = hcount[CNT_W-1 -: COLOR_W];
                w_g = hcount[CNT_W-1 -: COLOR_W];
                w_b = hcount[CNT_W-1 -: COLOR_W];
            end
            MODE_SCROLL: begin
                w_r = {COLOR_W{w_scr_on[2]}};
                w_g = {COLOR_W{w_scr_on[1]}};
                w_b = {COLOR_W{w_scr_on[0]}};
            end
            MODE_BLINK: begin
                if (!w_blink_ph) begin
                    w_r = w_cust_q[3*COLOR_W-1 -: COLOR_W];
                    w_g = w_cust_q[2*COLOR_W-1 -: COLOR_W];
                    w_b = w_cust_q[COLOR_W-1:0];
                end
            end
            default: begin
                w_r = M;
                w_g = ORANGE_G;
            end
        endcase
    end

    logic [COLOR_W-1:0] r_r;
    logic [COLOR_W-1:0] r_g;
    logic [COLOR_W-1:0] r_b;
    logic               r_act;

    // Output stage: blanking is applied here so the mux stays blanking-agnostic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_r   <= '0;
            r_g   <= '0;
            r_b   <= '0;
            r_act <= 1'b0;
        end else begin
            r_act <= active;
            r_r   <= active ? w_r : '0;
            r_g   <= active ? w_g : '0;
            r_b   <= active ? w_b : '0;
        end
    end

    assign r        = r_r;
    assign g        = r_g;
    assign b        = r_b;
    assign active_o = r_act;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen: the driver queues expected pixels,
// a monitor pops and compares one per clock after the output register.
module tb_vga_pattern_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       active = 1'b0;
    logic       frame_start = 1'b0;
    logic [9:0] hcount = '0;
    logic [9:0] vcount = '0;
    logic [3:0] sw = '0;
    logic [23:0] cust_rgb = '0;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       active_o;

    always #5 clk = ~clk;

    vga_pattern_gen dut (
        .clk         (clk),
        .rst         (rst),
        .active      (active),
        .frame_start (frame_start),
        .hcount      (hcount),
        .vcount      (vcount),
        .sw          (sw),
        .cust_rgb    (cust_rgb),
        .r           (r),
        .g           (g),
        .b           (b),
        .active_o    (active_o)
    );

    typedef struct packed {
        logic [31:0] tag;
        logic        chk;
        logic [23:0] rgb;
        logic        act;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_tag = 0;
    logic [3:0]  cur_sw = '0;
    logic [23:0] cur_cust = '0;

    task automatic drive(input logic act, input logic fs, input logic [9:0] h,
                         input logic [9:0] v, input logic chk, input logic [23:0] exp_rgb);
        exp_t e;
        @(negedge clk);
        active      = act;
        frame_start = fs;
        hcount      = h;
        vcount      = v;
        sw          = cur_sw;
        cust_rgb    = cur_cust;
        n_tag++;
        e.tag = n_tag;
        e.chk = chk;
        e.rgb = act ? exp_rgb : 24'h000000;
        e.act = act;
        sb_q.push_back(e);
    endtask

    task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic [23:0] exp_rgb);
        drive(1'b1, 1'b0, h, v, 1'b1, exp_rgb);
    endtask

    task automatic fsync();
        drive(1'b0, 1'b1, 10'd0, 10'd0, 1'b1, 24'h000000);
    endtask

    // Reset is asserted between clock edges; outputs must clear without an edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({r, g, b, active_o} !== 25'd0) begin
            n_bad++;
            $display("FAIL async_reset got rgb=%h act=%b expected rgb=000000 act=0",
                     {r, g, b}, active_o);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            if (mon_e.chk) begin
                n_cmp++;
                if ({r, g, b, active_o} !== {mon_e.rgb, mon_e.act}) begin
                    n_bad++;
                    $display("FAIL px%0d got rgb=%h act=%b expected rgb=%h act=%b",
                             mon_e.tag, {r, g, b}, active_o, mon_e.rgb, mon_e.act);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        cur_sw = 4'd0;
        fsync();
        pix(10'd100, 10'd50, 24'hFF0000);
        pix(10'd0,   10'd0,  24'hFF0000);

        // sw change mid-frame is held off until the next frame boundary
        cur_sw = 4'd2;
        pix(10'd200, 10'd50, 24'hFF0000);
        drive(1'b1, 1'b1, 10'd210, 10'd50, 1'b1, 24'hFF0000);
        pix(10'd0, 10'd1, 24'h0000FF);
        drive(1'b0, 1'b0, 10'd5, 10'd1, 1'b1, 24'h000000);
        pix(10'd300, 10'd60, 24'h0000FF);

        do_reset();
        pix(10'd300, 10'd60, 24'hFF0000);

        cur_sw = 4'd4;
        fsync();
        pix(10'd130, 10'd0, 24'h00FFFF);
        pix(10'd520, 10'd0, 24'hFFFFFF);
        pix(10'd64,  10'd0, 24'hFFFF00);
        pix(10'd448, 10'd0, 24'h000000);
        pix(10'd639, 10'd0, 24'hFFFF00);
        pix(10'd300, 10'd0, 24'hFF00FF);

        cur_sw = 4'd5;
        fsync();
        pix(10'd40, 10'd10, 24'hFFFFFF);
        pix(10'd40, 10'd40, 24'h000000);
        pix(10'd0,  10'd0,  24'h000000);
        pix(10'd31, 10'd32, 24'hFFFFFF);

        cur_sw = 4'd6;
        fsync();
        pix(10'd100, 10'd0, 24'h191919);
        pix(10'd636, 10'd0, 24'h9F9F9F);

        cur_sw = 4'd7;
        fsync();
        pix(10'd60, 10'd0, 24'hFFFFFF);
        pix(10'd64, 10'd0, 24'hFFFF00);
        fsync();
        pix(10'd62, 10'd0, 24'hFFFF00);
        pix(10'd61, 10'd0, 24'hFFFFFF);
        fsync();
        pix(10'd60, 10'd0, 24'hFFFF00);
        for (int k = 4; k <= 320; k++) fsync();
        pix(10'd5, 10'd0, 24'hFFFFFF);
        pix(10'd1, 10'd0, 24'hFFFF00);
        fsync();
        pix(10'd63, 10'd0, 24'hFFFFFF);
        pix(10'd64, 10'd0, 24'hFFFF00);
        fsync();
        pix(10'd62, 10'd0, 24'hFFFF00);
        cur_sw = 4'd4;
        fsync();
        cur_sw = 4'd7;
        fsync();
        pix(10'd63, 10'd0, 24'hFFFFFF);

        do_reset();
        cur_sw   = 4'd8;
        cur_cust = 24'h123456;
        for (int n = 1; n <= 60; n++) begin
            fsync();
            pix(10'd10, 10'd10, (((n / 30) % 2) == 1) ? 24'h000000 : 24'h123456);
        end

        cur_sw = 4'd3;
        fsync();
        pix(10'd20, 10'd20, 24'h123456);
        cur_cust = 24'hABCDEF;
        pix(10'd21, 10'd20, 24'h123456);
        fsync();
        pix(10'd22, 10'd20, 24'hABCDEF);

        cur_sw = 4'd9;
        fsync();
        pix(10'd5, 10'd5, 24'hFFAA00);
        cur_sw = 4'd15;
        fsync();
        pix(10'd6, 10'd5, 24'hFFAA00);
        cur_sw = 4'd1;
        fsync();
        pix(10'd7, 10'd5, 24'h00FF00);

        @(posedge clk);
        #2;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
